// File: rtl/sparse_pkg.sv
// sparse_pkg: shared FSM state, default sizing and counter-width helpers for the sparse memory writer.
package sparse_pkg;

    localparam int BUS_SIZE_DEF  = 32;
    localparam int MEM_SIZE_DEF  = 128;
    localparam int CHUNK_NUM_DEF = 8;
    localparam int DAT_CYC_NUM   = MEM_SIZE_DEF / BUS_SIZE_DEF;
    localparam int DAT_CNT_W     = $clog2(DAT_CYC_NUM);
    localparam int CHUNK_CNT_W   = $clog2(CHUNK_NUM_DEF);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sparse_mem_writer_if.sv
// sparse_mem_writer_if: dense input beat handshake plus the sparse memory write bus.
interface sparse_mem_writer_if
    import sparse_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF,
    parameter int DAT_W    = DAT_CNT_W,
    parameter int CHUNK_W  = CHUNK_CNT_W
);
    logic                  dense_valid_i;
    logic                  dense_ready_o;
    logic [BUS_SIZE*8-1:0] dense_data_i;
    logic [BUS_SIZE-1:0]   wr_sparsemap_o;
    logic [BUS_SIZE*8-1:0] wr_nonzero_data_o;
    logic                  wr_valid_o;
    logic [DAT_W-1:0]      wr_dat_count_o;
    logic [CHUNK_W-1:0]    wr_chunk_count_o;

    modport master (
        input  dense_valid_i, dense_data_i,
        output dense_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o,
               wr_dat_count_o, wr_chunk_count_o
    );

    modport slave (
        output dense_valid_i, dense_data_i,
        input  dense_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o,
               wr_dat_count_o, wr_chunk_count_o
    );
endinterface

// File: rtl/sparse_compactor.sv
// sparse_compactor: flags nonzero byte lanes and packs them, in ascending lane order, into the low output lanes.
module sparse_compactor
    import sparse_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF
) (
    input  logic [BUS_SIZE*8-1:0] data_i,
    output logic [BUS_SIZE-1:0]   map_o,
    output logic [BUS_SIZE*8-1:0] data_o
);
    for (genvar k = 0; k < BUS_SIZE; k++) begin : g_map
        assign map_o[k] = |data_i[8*k +: 8];
    end

    // pos is the running prefix count of nonzero lanes below lane k, i.e. its output slot.
    always_comb begin
        int pos;
        data_o = '0;
        pos = 0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            if (map_o[k]) begin
                data_o[8*pos +: 8] = data_i[8*k +: 8];
                pos = pos + 1;
            end
        end
    end
endmodule

// File: rtl/sparse_mem_writer.sv
// sparse_mem_writer: streams dense beats into consecutive memory chunks as sparsemap plus compacted bytes.
module sparse_mem_writer
    import sparse_pkg::*;
#(
    parameter int  BUS_SIZE  = BUS_SIZE_DEF,
    parameter int  MEM_SIZE  = MEM_SIZE_DEF,
    parameter int  CHUNK_NUM = CHUNK_NUM_DEF,
    localparam int DCN       = MEM_SIZE / BUS_SIZE,
    localparam int DW        = cnt_w(DCN),
    localparam int CW        = cnt_w(CHUNK_NUM),
    localparam int LW        = CW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [CW-1:0] chunk_base_i,
    input  logic [LW-1:0] chunk_len_i,
    output logic          busy_o,
    output logic          done_o,
    sparse_mem_writer_if.master bus
);
    state_t                state_q, state_d;
    logic [DW-1:0]         dat_q, dat_d, wr_dat_q, wr_dat_d;
    logic [CW-1:0]         chunk_q, chunk_d, wr_chunk_q, wr_chunk_d;
    logic [LW-1:0]         rem_q, rem_d;
    logic [BUS_SIZE-1:0]   map, wr_map_q, wr_map_d;
    logic [BUS_SIZE*8-1:0] packed_data, wr_data_q, wr_data_d;
    logic                  wr_valid_q, wr_valid_d, done_q, done_d;
    logic                  xfer, last_beat;

    sparse_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
        .data_i (bus.dense_data_i),
        .map_o  (map),
        .data_o (packed_data)
    );

    assign xfer      = (state_q == LOAD) && bus.dense_valid_i;
    assign last_beat = dat_q == DW'(DCN - 1);

    // rem_q counts chunks still to finish; chunk_q is the wrapped target chunk index.
    always_comb begin
        state_d    = state_q;
        dat_d      = dat_q;
        chunk_d    = chunk_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        wr_valid_d = xfer;
        wr_map_d   = xfer ? map : wr_map_q;
        wr_data_d  = xfer ? packed_data : wr_data_q;
        wr_dat_d   = xfer ? dat_q : wr_dat_q;
        wr_chunk_d = xfer ? chunk_q : wr_chunk_q;
        if (state_q == IDLE && start_i) begin
            if (chunk_len_i != '0) begin
                state_d = LOAD;
                dat_d   = '0;
                chunk_d = chunk_base_i;
                rem_d   = chunk_len_i;
            end else begin
                done_d = 1'b1;
            end
        end
        if (xfer) begin
            dat_d = last_beat ? '0 : dat_q + 1'b1;
            if (last_beat) begin
                chunk_d = (chunk_q == CW'(CHUNK_NUM - 1)) ? '0 : chunk_q + 1'b1;
                rem_d   = rem_q - 1'b1;
            end
            if (last_beat && rem_q == LW'(1)) begin
                state_d = FLUSH;
                done_d  = 1'b1;
            end
        end
        if (state_q == FLUSH) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dat_q      <= '0;
            chunk_q    <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_map_q   <= '0;
            wr_data_q  <= '0;
            wr_dat_q   <= '0;
            wr_chunk_q <= '0;
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            chunk_q    <= chunk_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            wr_valid_q <= wr_valid_d;
            wr_map_q   <= wr_map_d;
            wr_data_q  <= wr_data_d;
            wr_dat_q   <= wr_dat_d;
            wr_chunk_q <= wr_chunk_d;
        end
    end

    assign busy_o                = state_q != IDLE;
    assign done_o                = done_q;
    assign bus.dense_ready_o     = state_q == LOAD;
    assign bus.wr_valid_o        = wr_valid_q;
    assign bus.wr_sparsemap_o    = wr_map_q;
    assign bus.wr_nonzero_data_o = wr_data_q;
    assign bus.wr_dat_count_o    = wr_dat_q;
    assign bus.wr_chunk_count_o  = wr_chunk_q;
endmodule

// File: tb/tb_sparse_mem_writer.sv
// tb_sparse_mem_writer: directed vectors for the sparse memory writer with hand-computed expectations.
module tb_sparse_mem_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] base = '0;
    logic [3:0] len = '0;
    logic       busy, done;
    int         n_chk = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    int         busy_cnt = 0;

    typedef struct {
        logic [2:0]   ch;
        logic [1:0]   dc;
        logic [31:0]  map;
        logic [255:0] dat;
        logic         dn;
    } wr_t;
    wr_t wq[$];

    sparse_mem_writer_if bus();

    sparse_mem_writer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .chunk_base_i (base),
        .chunk_len_i  (len),
        .busy_o       (busy),
        .done_o       (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.wr_valid_o)
            wq.push_back('{ch: bus.wr_chunk_count_o, dc: bus.wr_dat_count_o,
                           map: bus.wr_sparsemap_o, dat: bus.wr_nonzero_data_o, dn: done});
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] b, input logic [3:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [255:0] d);
        bus.dense_valid_i = 1'b1;
        bus.dense_data_i  = d;
        tick();
        bus.dense_valid_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ready"}, bus.dense_ready_o, 0);
        chk({tag, "_valid"}, bus.wr_valid_o, 0);
        chk({tag, "_map"}, bus.wr_sparsemap_o, 0);
        chk({tag, "_data"}, bus.wr_nonzero_data_o, 0);
        chk({tag, "_dat"}, bus.wr_dat_count_o, 0);
        chk({tag, "_chunk"}, bus.wr_chunk_count_o, 0);
    endtask

    task automatic clear();
        wq.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    initial begin
        logic [255:0] d;
        bus.dense_valid_i = 1'b0;
        bus.dense_data_i  = '0;
        repeat (2) tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();

        // single chunk: zero beat, mixed beat, hold on idle cycle, full beat, one-lane beat
        go(3'd3, 4'd1);
        chk("start_ready", bus.dense_ready_o, 1);
        chk("start_busy", busy, 1);
        beat('0);
        chk("z_valid", bus.wr_valid_o, 1);
        chk("z_map", bus.wr_sparsemap_o, 0);
        chk("z_data", bus.wr_nonzero_data_o, 0);
        chk("z_dat", bus.wr_dat_count_o, 0);
        chk("z_chunk", bus.wr_chunk_count_o, 3);
        d = '0;
        d[15:8]    = 8'h05;
        d[39:32]   = 8'hAA;
        d[255:248] = 8'h01;
        beat(d);
        chk("mix_valid", bus.wr_valid_o, 1);
        chk("mix_map", bus.wr_sparsemap_o, 32'h8000_0012);
        chk("mix_data", bus.wr_nonzero_data_o, 256'h01AA05);
        chk("mix_dat", bus.wr_dat_count_o, 1);
        tick();
        chk("hold_valid", bus.wr_valid_o, 0);
        chk("hold_map", bus.wr_sparsemap_o, 32'h8000_0012);
        chk("hold_data", bus.wr_nonzero_data_o, 256'h01AA05);
        chk("hold_dat", bus.wr_dat_count_o, 1);
        for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k + 1);
        beat(d);
        chk("full_map", bus.wr_sparsemap_o, 32'hFFFF_FFFF);
        chk("full_data", bus.wr_nonzero_data_o, d);
        chk("full_dat", bus.wr_dat_count_o, 2);
        chk("full_done", done, 0);
        d = '0;
        d[255:248] = 8'h7F;
        beat(d);
        chk("last_map", bus.wr_sparsemap_o, 32'h8000_0000);
        chk("last_data", bus.wr_nonzero_data_o, 256'h7F);
        chk("last_dat", bus.wr_dat_count_o, 3);
        chk("last_valid", bus.wr_valid_o, 1);
        chk("last_done", done, 1);
        chk("last_ready", bus.dense_ready_o, 0);
        tick();
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("after_ready", bus.dense_ready_o, 0);
        repeat (2) tick();

        // chunk index wraps from 7 to 0 with continuous valid
        clear();
        go(3'd7, 4'd2);
        bus.dense_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.dense_data_i = 256'(i + 1);
            tick();
        end
        bus.dense_valid_i = 1'b0;
        repeat (4) tick();
        chk("wrap_n", wq.size(), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            chk("wrap_ch", wq[i].ch, (i < 4) ? 7 : 0);
            chk("wrap_dc", wq[i].dc, i % 4);
            chk("wrap_dat", wq[i].dat, i + 1);
            chk("wrap_dn", wq[i].dn, i == 7);
        end
        chk("wrap_busy", busy_cnt, 9);
        chk("wrap_done", done_cnt, 1);

        // valid toggling every other cycle
        clear();
        go(3'd0, 4'd1);
        for (int i = 0; i < 8; i++) begin
            bus.dense_valid_i = (i % 2 == 0);
            bus.dense_data_i  = 256'(8'h10 + i);
            tick();
        end
        bus.dense_valid_i = 1'b0;
        repeat (3) tick();
        chk("stall_n", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk("stall_ch", wq[i].ch, 0);
            chk("stall_dc", wq[i].dc, i);
            chk("stall_dat", wq[i].dat, 8'h10 + 2 * i);
            chk("stall_dn", wq[i].dn, i == 3);
        end
        chk("stall_done", done_cnt, 1);

        // asynchronous reset after two beats aborts the command
        clear();
        go(3'd2, 4'd1);
        beat(256'h1);
        beat(256'h2);
        #2 rst = 1'b1;
        #1 chk_zero("arst");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("arst_n", wq.size(), 2);
        chk("arst_done", done_cnt, 0);
        chk("arst_busy", busy, 0);
        clear();
        go(3'd5, 4'd1);
        bus.dense_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.dense_data_i = 256'(8'h21 + i);
            tick();
        end
        bus.dense_valid_i = 1'b0;
        repeat (3) tick();
        chk("rerun_n", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk("rerun_ch", wq[i].ch, 5);
            chk("rerun_dc", wq[i].dc, i);
        end
        chk("rerun_done", done_cnt, 1);

        // start during LOAD is ignored
        clear();
        go(3'd1, 4'd1);
        beat(256'h9);
        go(3'd6, 4'd3);
        chk("ign_busy", busy, 1);
        bus.dense_valid_i = 1'b1;
        bus.dense_data_i  = 256'h3;
        repeat (3) tick();
        bus.dense_valid_i = 1'b0;
        repeat (3) tick();
        chk("ign_n", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk("ign_ch", wq[i].ch, 1);
            chk("ign_dc", wq[i].dc, i);
        end
        chk("ign_done", done_cnt, 1);
        chk("ign_idle", busy, 0);

        // zero-length command completes without any write
        clear();
        go(3'd4, 4'd0);
        chk("z0_done", done, 1);
        chk("z0_busy", busy, 0);
        chk("z0_valid", bus.wr_valid_o, 0);
        tick();
        chk("z0_done_drop", done, 0);
        repeat (2) tick();
        chk("z0_n", wq.size(), 0);
        chk("z0_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
